alu_rr_scheduler: RTL and testbench

- Shares one 4-bit ALU between two requesters using a valid/ready request interface and a registered response channel.
- The ALU supports four functions: add, OR-reduce, AND-reduce and concatenate.
- Each request is arbitrated round-robin (or fixed priority), executed on latched operands, and returned with the winner's ID.
- Sits between the lab switch/key front-ends and the HEX/LED display logic.

---
 rtl/alu_rr_if.sv | 34 +++
 rtl/alu_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rr_if.sv
// Request/response bundle between two ALU requesters and the shared scheduler.
// master: requesters + response consumer; slave: alu_rr_scheduler.
interface alu_rr_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_A;
  logic [3:0] req0_B;
  logic [1:0] req0_Function;
  logic [3:0] req1_A;
  logic [3:0] req1_B;
  logic [1:0] req1_Function;
  logic       resp_valid;
  logic       resp_id;
  logic [7:0] resp_ALUout;
  logic       resp_ready;

  modport master (
    output req_valid,
    output req0_A, req0_B, req0_Function,
    output req1_A, req1_B, req1_Function,
    output resp_ready,
    input  req_ready,
    input  resp_valid, resp_id, resp_ALUout
  );

  modport slave (
    input  req_valid,
    input  req0_A, req0_B, req0_Function,
    input  req1_A, req1_B, req1_Function,
    input  resp_ready,
    output req_ready,
    output resp_valid, resp_id, resp_ALUout
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Shares one 4-bit ALU between two requesters (round-robin or fixed priority).
// Ports: Clock, Reset_b (async low), bus (alu_rr_if.slave), op_count.
module alu_rr_scheduler #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset_b,
  alu_rr_if.slave          bus,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       last_grant;
  logic       grant;
  logic       win;
  logic       hs;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] fn_q;
  logic       id_q;
  logic [4:0] sum;
  logic [7:0] alu;

  assign hs = (state == RESP) && bus.resp_ready;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Grant is suppressed while reset is held so req_ready reads 0.
  always_comb begin
    grant    = 1'b0;
    win      = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Reset_b) begin
          unique case (bus.req_valid)
            2'b01: begin
              grant = 1'b1;
              win   = 1'b0;
            end
            2'b10: begin
              grant = 1'b1;
              win   = 1'b1;
            end
            2'b11: begin
              grant = 1'b1;
              win   = (RR_EN != 0) ? ~last_grant : 1'b0;
            end
            default: begin
              grant = 1'b0;
            end
          endcase
        end
        if (grant) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    if (grant) begin
      bus.req_ready = win ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    alu = 8'h00;
    unique case (fn_q)
      2'd0: alu = {3'b000, sum};
      2'd1: alu = {7'b0, |{a_q, b_q}};
      2'd2: alu = {7'b0, &{a_q, b_q}};
      2'd3: alu = {a_q, b_q};
      default: alu = 8'h00;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      a_q             <= 4'h0;
      b_q             <= 4'h0;
      fn_q            <= 2'd0;
      id_q            <= 1'b0;
      last_grant      <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_ALUout <= 8'h00;
      op_count        <= '0;
    end else begin
      if (grant) begin
        a_q  <= win ? bus.req1_A : bus.req0_A;
        b_q  <= win ? bus.req1_B : bus.req0_B;
        fn_q <= win ? bus.req1_Function
                    : bus.req0_Function;
        id_q <= win;
      end
      if (state == EXEC) begin
        bus.resp_ALUout <= alu;
        bus.resp_id     <= id_q;
        bus.resp_valid  <= 1'b1;
      end
      if (hs) begin
        bus.resp_valid <= 1'b0;
        last_grant     <= bus.resp_id;
        op_count       <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus.
// A transaction-level model predicts grants/results; a monitor checks responses.
module tb_alu_rr_scheduler;

  logic       Clock;
  logic       Reset_b;
  logic [1:0] req_valid;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] f0, f1;
  logic       resp_ready;
  logic [7:0] cnt_rr;
  logic [7:0] cnt_fp;

  int errors = 0;
  int checks = 0;

  alu_rr_if bus0 ();
  alu_rr_if bus1 ();

  assign bus0.req_valid     = req_valid;
  assign bus0.req0_A        = a0;
  assign bus0.req0_B        = b0;
  assign bus0.req0_Function = f0;
  assign bus0.req1_A        = a1;
  assign bus0.req1_B        = b1;
  assign bus0.req1_Function = f1;
  assign bus0.resp_ready    = resp_ready;
  assign bus1.req_valid     = req_valid;
  assign bus1.req0_A        = a0;
  assign bus1.req0_B        = b0;
  assign bus1.req0_Function = f0;
  assign bus1.req1_A        = a1;
  assign bus1.req1_B        = b1;
  assign bus1.req1_Function = f1;
  assign bus1.resp_ready    = resp_ready;

  alu_rr_scheduler #(.RR_EN(1), .CNT_W(8)) dut_rr (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus0),
    .op_count(cnt_rr)
  );

  alu_rr_scheduler #(.RR_EN(0), .CNT_W(8)) dut_fp (
    .Clock   (Clock),
    .Reset_b (Reset_b),
    .bus     (bus1),
    .op_count(cnt_fp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [1:0] o_rdy [2];
  logic       o_rv  [2];
  logic       o_id  [2];
  logic [7:0] o_out [2];
  logic [7:0] o_cnt [2];

  assign o_rdy[0] = bus0.req_ready;
  assign o_rdy[1] = bus1.req_ready;
  assign o_rv[0]  = bus0.resp_valid;
  assign o_rv[1]  = bus1.resp_valid;
  assign o_id[0]  = bus0.resp_id;
  assign o_id[1]  = bus1.resp_id;
  assign o_out[0] = bus0.resp_ALUout;
  assign o_out[1] = bus1.resp_ALUout;
  assign o_cnt[0] = cnt_rr;
  assign o_cnt[1] = cnt_fp;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h want %0h t=%0t",
               nm, d, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_alu(
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] f);
    int s;
    case (f)
      2'd0: begin
        s = int'(a) + int'(b);
        return 8'(s);
      end
      2'd1: return ((a != 0) || (b != 0)) ? 8'h01 : 8'h00;
      2'd2: return ((a == 4'hF) && (b == 4'hF)) ? 8'h01 : 8'h00;
      default: return {a, b};
    endcase
  endfunction

  // Model: per instance, an operation is "idle" (0), "computing" (1)
  // or "awaiting consumer" (2); expected {id,result} queued at accept.
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int         ph   [2];
  logic       last [2];
  logic       cur  [2];
  logic [7:0] mcnt [2];

  always @(negedge Clock) begin
    logic       w;
    logic [1:0] er;
    logic [7:0] r;
    if (!Reset_b) begin
      for (int d = 0; d < 2; d++) begin
        ph[d]   = 0;
        last[d] = 1'b1;
        mcnt[d] = 8'h00;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (req_valid == 2'b11)
          w = (d == 0) ? ~last[d] : 1'b0;
        else
          w = req_valid[1];
        er = 2'b00;
        if (ph[d] == 0 && req_valid != 2'b00)
          er = w ? 2'b10 : 2'b01;
        chk("req_ready", d, 32'(o_rdy[d]), 32'(er));
        chk("resp_valid", d, 32'(o_rv[d]),
            32'(ph[d] == 2));
        chk("op_count", d, 32'(o_cnt[d]), 32'(mcnt[d]));
        if (ph[d] == 0) begin
          if (req_valid != 2'b00) begin
            r = w ? ref_alu(a1, b1, f1)
                  : ref_alu(a0, b0, f0);
            if (d == 0) q0.push_back({w, r});
            else        q1.push_back({w, r});
            cur[d] = w;
            ph[d]  = 1;
          end
        end else if (ph[d] == 1) begin
          ph[d] = 2;
        end else if (resp_ready) begin
          last[d] = cur[d];
          mcnt[d] = mcnt[d] + 8'h01;
          ph[d]   = 0;
        end
      end
    end
  end

  // Monitor: pop on every response handshake; stalled responses stay put.
  logic       held [2];
  logic [8:0] snap [2];

  always @(negedge Clock) begin
    logic [8:0] e;
    logic [8:0] a;
    for (int d = 0; d < 2; d++) begin
      a = {o_id[d], o_out[d]};
      if (!Reset_b) begin
        held[d] = 1'b0;
      end else begin
        if (held[d] && o_rv[d])
          chk("resp_stable", d, 32'(a), 32'(snap[d]));
        if (o_rv[d] && resp_ready) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk("resp_unexpected", d, 32'(a), 32'h1ff);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("resp_id", d, 32'(o_id[d]), 32'(e[8]));
            chk("resp_ALUout", d, 32'(o_out[d]),
                32'(e[7:0]));
          end
        end
        held[d] = o_rv[d] && !resp_ready;
        snap[d] = a;
      end
    end
  end

  task automatic drive(input logic [1:0] v,
                       input logic [3:0] xa0, input logic [3:0] xb0,
                       input logic [1:0] xf0,
                       input logic [3:0] xa1, input logic [3:0] xb1,
                       input logic [1:0] xf1, input logic rdy);
    req_valid  = v;
    a0 = xa0; b0 = xb0; f0 = xf0;
    a1 = xa1; b1 = xb1; f1 = xf1;
    resp_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, 32'(o_rdy[d]), 32'h0);
      chk("rst_resp_valid", d, 32'(o_rv[d]), 32'h0);
      chk("rst_resp_id", d, 32'(o_id[d]), 32'h0);
      chk("rst_resp_ALUout", d, 32'(o_out[d]), 32'h0);
      chk("rst_op_count", d, 32'(o_cnt[d]), 32'h0);
    end
  endtask

  initial begin
    int n;
    Reset_b = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    chk_reset_vals();
    tick(2);
    Reset_b = 1'b1;

    // single add with carry
    drive(2'b01, 4'hF, 4'h1, 2'd0, 0, 0, 0, 1'b1);
    tick(1);
    drive(2'b00, 4'hF, 4'h1, 2'd0, 0, 0, 0, 1'b1);
    tick(4);

    // both requesters continuously valid
    drive(2'b11, 4'hA, 4'h5, 2'd3, 4'hF, 4'hF, 2'd2, 1'b1);
    tick(12);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    tick(3);

    // OR/AND reduce corners
    drive(2'b01, 4'h0, 4'h0, 2'd1, 0, 0, 0, 1'b1);
    tick(3);
    drive(2'b01, 4'h0, 4'h8, 2'd1, 0, 0, 0, 1'b1);
    tick(3);
    drive(2'b01, 4'hF, 4'hE, 2'd2, 0, 0, 0, 1'b1);
    tick(3);
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    tick(3);

    // consumer stall while operands churn
    drive(2'b01, 4'h7, 4'h9, 2'd0, 0, 0, 0, 1'b0);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 4'($urandom), 4'($urandom), 2'($urandom),
            4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
      tick(1);
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    tick(4);

    // reset in the middle of an operation
    drive(2'b10, 0, 0, 0, 4'h3, 4'h4, 2'd3, 1'b1);
    tick(1);
    Reset_b = 1'b0;
    #1;
    chk_reset_vals();
    tick(1);
    Reset_b = 1'b1;
    drive(2'b11, 4'h2, 4'h2, 2'd0, 4'h1, 4'h1, 2'd0, 1'b1);
    tick(6);

    // enough completions to wrap the 8-bit counter
    drive(2'b11, 4'hC, 4'h6, 2'd0, 4'h9, 4'h9, 2'd3, 1'b1);
    tick(3 * 258);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), ($urandom_range(0, 9) < 7));
      tick(1);
    end

    // drain, bounded
    drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      tick(1);
      n++;
    end
    tick(1);
    chk("drain_q_rr", 0, 32'(q0.size()), 32'h0);
    chk("drain_q_fp", 1, 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
